fifo_channel: RTL and testbench

FIFO_CHANNEL -- requirements
Module: fifo_channel

---
 rtl/fifo_channel_pkg.sv | 21 ++
 rtl/fifo_channel_mem.sv | 38 +++
 rtl/fifo_channel.sv | 119 +++++++++++
 tb/tb_fifo_channel.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_channel_pkg.sv
// Shared constants and sizing helper for the fifo_channel block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_channel_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 4;

    // Pointer width for a power-of-two depth; never less than 1 bit.
    function automatic int ptr_w(input int depth);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/fifo_channel_mem.sv
// Storage array for fifo_channel: one synchronous write port, one asynchronous read port.
// Latency: write lands on the rising edge; read data is combinational from rd_addr.
// Backpressure: none here; the controller only asserts wr_en for accepted writes.
//
// Ports:
//   clk      - clock
//   wr_en    - write enable (already qualified by flags and reset)
//   wr_addr  - write address
//   wr_data  - write data
//   rd_addr  - read address
//   rd_data  - read data at rd_addr
// The array is deliberately not reset.
module fifo_channel_mem
    import fifo_channel_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    localparam int AW        = ptr_w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_channel.sv
// First-word-fall-through FIFO channel with registered full/empty flags.
// Latency: a word written into an empty FIFO is readable 1 cycle later (no bypass).
// Backpressure: writes are dropped while if_full_n=0, reads ignored while if_empty_n=0.
//
// Ports:
//   ap_clk     - clock, all state on rising edge
//   ap_rst_n   - synchronous active-low reset
//   if_din     - producer write data
//   if_full_n  - high when a write will be accepted (registered)
//   if_write   - producer write strobe
//   if_dout    - head word; holds last shown value while empty, 0 after reset
//   if_empty_n - high when a word is readable (registered)
//   if_read    - consumer read strobe
//   if_count   - live occupancy        (only with FIFO_CHANNEL_STATS_EN)
//   if_peak    - sticky max occupancy  (only with FIFO_CHANNEL_STATS_EN)
module fifo_channel
    import fifo_channel_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    localparam int PW        = ptr_w(DEPTH),
    localparam int CW        = PW + 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_write,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    input  logic                  if_read
`ifdef FIFO_CHANNEL_STATS_EN
    ,
    output logic [CW-1:0]         if_count,
    output logic [CW-1:0]         if_peak
`endif
);

    logic [PW-1:0]         wptr;
    logic [PW-1:0]         rptr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_nxt;
    logic                  full_n;
    logic                  empty_n;
    logic                  wr_ok;
    logic                  rd_ok;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] dout_hold;

    // Flags are registers, so acceptance never depends combinationally on the strobes' effect.
    assign wr_ok = if_write & full_n;
    assign rd_ok = if_read & empty_n;

    always_comb begin
        count_nxt = count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            full_n    <= 1'b1;
            empty_n   <= 1'b0;
            dout_hold <= '0;
        end else begin
            // Power-of-two depth: natural overflow wraps DEPTH-1 -> 0.
            if (wr_ok) begin
                wptr <= wptr + PW'(1);
            end
            if (rd_ok) begin
                rptr <= rptr + PW'(1);
            end
            count     <= count_nxt;
            full_n    <= (count_nxt != CW'(DEPTH));
            empty_n   <= (count_nxt != '0);
            // Tracks what the consumer last saw so the output freezes once empty.
            dout_hold <= if_dout;
        end
    end

    fifo_channel_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk     (ap_clk),
        .wr_en   (wr_ok & ap_rst_n),
        .wr_addr (wptr),
        .wr_data (if_din),
        .rd_addr (rptr),
        .rd_data (mem_rdata)
    );

    // Storage is never reset, so the held register masks it until a word exists.
    assign if_dout    = empty_n ? mem_rdata : dout_hold;
    assign if_full_n  = full_n;
    assign if_empty_n = empty_n;

`ifdef FIFO_CHANNEL_STATS_EN
    logic [CW-1:0] peak;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            peak <= '0;
        end else if (count_nxt > peak) begin
            peak <= count_nxt;
        end
    end

    assign if_count = count;
    assign if_peak  = peak;
`endif

endmodule

// File: tb/tb_fifo_channel.sv
// Self-checking bench for fifo_channel: directed scenarios plus randomized traffic.
// Latency: reference model updates on each rising edge; outputs sampled on falling edge.
// Backpressure: the model drops writes when it holds DEPTH words and ignores empty reads.
module tb_fifo_channel;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          ap_clk;
    logic          ap_rst_n;
    logic [DW-1:0] if_din;
    logic          if_full_n;
    logic          if_write;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
    logic          if_read;
`ifdef FIFO_CHANNEL_STATS_EN
    logic [CW-1:0] if_count;
    logic [CW-1:0] if_peak;
`endif

    fifo_channel #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .if_din     (if_din),
        .if_full_n  (if_full_n),
        .if_write   (if_write),
        .if_dout    (if_dout),
        .if_empty_n (if_empty_n),
        .if_read    (if_read)
`ifdef FIFO_CHANNEL_STATS_EN
        ,
        .if_count   (if_count),
        .if_peak    (if_peak)
`endif
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of stored words plus the last value shown.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_hold = '0;
    int            model_peak = 0;
    bit            armed      = 1'b0;

    always @(posedge ap_clk) begin
        bit do_wr;
        bit do_rd;
        if (!ap_rst_n) begin
            model_q.delete();
            model_hold = '0;
            model_peak = 0;
            armed      = 1'b1;
        end else begin
            do_wr = if_write && (model_q.size() < DEPTH);
            do_rd = if_read && (model_q.size() > 0);
            if (do_rd) void'(model_q.pop_front());
            if (do_wr) model_q.push_back(if_din);
            if (model_q.size() > model_peak) model_peak = model_q.size();
        end
    end

    // Monitor: compares flags and head word against the model every cycle.
    always @(negedge ap_clk) begin
        logic [DW-1:0] exp_dout;
        if (armed) begin
            exp_dout = (model_q.size() > 0) ? model_q[0] : model_hold;
            check("dout", if_dout, exp_dout);
            model_hold = exp_dout;
            check("empty_n", {31'd0, if_empty_n}, {31'd0, model_q.size() != 0});
            check("full_n", {31'd0, if_full_n}, {31'd0, model_q.size() != DEPTH});
`ifdef FIFO_CHANNEL_STATS_EN
            check("count", {29'd0, if_count}, DW'(model_q.size()));
            check("peak", {29'd0, if_peak}, DW'(model_peak));
`endif
        end
    end

    // One clock of stimulus; returns 1 time unit after the edge.
    task automatic cyc(input logic rst_n, input logic wr, input logic [DW-1:0] d, input logic rd);
        ap_rst_n = rst_n;
        if_write = wr;
        if_din   = d;
        if_read  = rd;
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        if_write = 1'b0;
        if_read  = 1'b0;
    endtask

    initial begin
        ap_rst_n = 1'b0;
        if_write = 1'b0;
        if_read  = 1'b0;
        if_din   = '0;
        @(posedge ap_clk);
        #1;
        cyc(1'b0, 1'b1, 32'hDEAD, 1'b1);
        check("rst_empty_n", {31'd0, if_empty_n}, 32'd0);
        check("rst_full_n", {31'd0, if_full_n}, 32'd1);
        check("rst_dout", if_dout, 32'd0);

        // Underflow, then single-word latency.
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
        check("underflow_empty_n", {31'd0, if_empty_n}, 32'd0);
        check("underflow_dout", if_dout, 32'd0);
        cyc(1'b1, 1'b1, 32'hA5, 1'b0);
        check("latency_empty_n", {31'd0, if_empty_n}, 32'd1);
        check("latency_dout", if_dout, 32'hA5);
        cyc(1'b1, 1'b0, 32'd0, 1'b1);
        check("drain_a5_empty_n", {31'd0, if_empty_n}, 32'd0);
        check("hold_dout", if_dout, 32'hA5);

        // Fill, overflow attempt, drain.
        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, DW'(i * 'h11), 1'b0);
        check("fill_full_n", {31'd0, if_full_n}, 32'd0);
        cyc(1'b1, 1'b1, 32'h55, 1'b0);
        check("overflow_full_n", {31'd0, if_full_n}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            check("drain_word", if_dout, DW'(i * 'h11));
            cyc(1'b1, 1'b0, 32'd0, 1'b1);
        end
        check("drain_empty_n", {31'd0, if_empty_n}, 32'd0);
        check("drain_full_n", {31'd0, if_full_n}, 32'd1);

        // Simultaneous write and read at count 2 across pointer wrap.
        cyc(1'b1, 1'b1, 32'h60, 1'b0);
        cyc(1'b1, 1'b1, 32'h61, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check("simul_word", if_dout, DW'('h60 + i));
            cyc(1'b1, 1'b1, DW'('h62 + i), 1'b1);
            check("simul_full_n", {31'd0, if_full_n}, 32'd1);
            check("simul_empty_n", {31'd0, if_empty_n}, 32'd1);
        end

        // Mid-operation reset with count 3; strobes during reset are ignored.
        cyc(1'b1, 1'b1, 32'h70, 1'b0);
        check("pre_rst_full_n", {31'd0, if_full_n}, 32'd1);
        cyc(1'b0, 1'b1, 32'h99, 1'b1);
        check("midrst_empty_n", {31'd0, if_empty_n}, 32'd0);
        check("midrst_full_n", {31'd0, if_full_n}, 32'd1);
        cyc(1'b1, 1'b1, 32'h77, 1'b0);
        check("post_rst_first", if_dout, 32'h77);
        cyc(1'b1, 1'b0, 32'd0, 1'b1);

`ifdef FIFO_CHANNEL_STATS_EN
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, DW'(i), 1'b0);
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, 32'd0, 1'b1);
        check("stats_count", {29'd0, if_count}, 32'd1);
        check("stats_peak", {29'd0, if_peak}, 32'd3);
        cyc(1'b0, 1'b0, 32'd0, 1'b0);
        check("stats_peak_rst", {29'd0, if_peak}, 32'd0);
`endif

        // Randomized traffic with a write/read bias that flips periodically.
        for (int i = 0; i < 600; i++) begin
            int wp;
            wp = ((i / 50) % 2 == 0) ? 70 : 30;
            cyc(($urandom_range(0, 99) != 0),
                ($urandom_range(0, 99) < wp),
                $urandom,
                ($urandom_range(0, 99) < (100 - wp)));
        end

        @(negedge ap_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
